cpu_seq_ctrl: RTL and testbench
===============================

CPU_SEQ_CTRL -- requirements
Module: cpu_seq_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low; low forces reset state immediately.
REQ-004 SHALL have port run, input, 1 bit: when high, FETCH may start a new instruction.
REQ-005 SHALL have port instr_req, output, 1 bit: fetch request.
REQ-006 SHALL have port instr_valid, input, 1 bit: fetch acknowledge.
REQ-007 SHALL have port instr_in, input, 32 bits: fetched instruction.
REQ-008 SHALL have port instr, output, 32 bits: latched instruction register (IR) to the datapath.
REQ-009 SHALL have ports zero, ZF, NF, OF, CoF, inputs, 1 bit each: live ALU zero and registered flags.
REQ-010 SHALL have ports Reg2Loc, RegWrite, MemWrite, SetFlag, loadB (1 bit each), ALUSrc[1:0], MemToReg[1:0], ALUOp[2:0] and xfer_size[3:0], all outputs.
REQ-011 SHALL have ports pc_we (1 bit) and pc_sel (2 bits: 0 = PC+4, 1 = PC+BrAddr26, 2 = PC+CondAddr19), outputs.
REQ-012 SHALL have ports err (1 bit) and retired (CNT_W bits), outputs.

Function
REQ-013 SHALL be an FSM with states IDLE, FETCH, DECODE, EXEC, MEM, WB, ERR.
REQ-014 IDLE -> FETCH when run=1; FETCH holds instr_req=1 until instr_valid=1, then latches instr_in into IR and goes to DECODE.
REQ-015 DECODE -> ERR on an unsupported opcode; otherwise -> EXEC.
REQ-016 Supported opcodes: ADDI, ADDS, SUBS, LDUR, LDURB, STUR, STURB, MOVZ, MOVK, B, B.cond, CBZ.
REQ-017 ALUOp encoding: 000 = pass B, 010 = add, 011 = subtract.
REQ-018 ALUSrc encoding: 0 = Db, 1 = DAddr9 sign-extended, 2 = Imm12 zero-extended.
REQ-019 MemToReg encoding: 0 = ALU, 1 = memory, 2 = MOVZ, 3 = MOVK.
REQ-020 Reg2Loc encoding: 1 selects Rm [20:16]; 0 selects Rd [4:0].
REQ-021 Path, ADDI/ADDS/SUBS: EXEC -> WB; SetFlag=1 for exactly one cycle, in EXEC, only for ADDS/SUBS.
REQ-022 Path, loads: EXEC -> MEM -> WB; ALUSrc=1, ALUOp=010, MemToReg=1.
REQ-023 Loads: xfer_size=8 for LDUR; xfer_size=1 with loadB=1 for LDURB.
REQ-024 Path, stores: EXEC -> MEM -> FETCH/IDLE; MemWrite=1 for exactly one cycle, in MEM; Reg2Loc=0; no WB.
REQ-025 Path, MOVZ/MOVK: EXEC -> WB; MOVK uses Reg2Loc=0 so that Db = Rd.
REQ-026 RegWrite=1 for exactly one cycle, in WB only; RegWrite and MemWrite are never both high.
REQ-027 Branches resolve in EXEC: pc_we=1 for one cycle; pc_sel=1 for B.
REQ-028 CBZ: Reg2Loc=0, ALUOp=000; taken when zero=1 in EXEC.
REQ-029 B.cond taken per cond [3:0]: 0 ZF; 1 !ZF; A NF==OF; B NF!=OF; C !ZF&&NF==OF; D ZF||NF!=OF; all other codes not taken.
REQ-030 A taken conditional branch drives pc_sel=2; a not-taken one drives pc_sel=0.
REQ-031 Non-branch instructions assert pc_we=1 with pc_sel=0 in their final state.
REQ-032 The final state of every instruction increments retired by 1, wrapping modulo 2^CNT_W, then -> FETCH if run=1, else IDLE.
REQ-033 ERR is sticky until reset: err=1 and all write enables 0.
REQ-034 Outside the listed assertions, every enable output SHALL be 0 and every mux select SHALL be 0.
REQ-035 run=0 SHALL only take effect at an instruction boundary; an instruction in progress always completes.

Reset
REQ-036 Reset low SHALL force state=IDLE, IR=0, retired=0, err=0, and every output to 0 asynchronously.
REQ-037 Reset asserted mid-instruction SHALL abort it with no write-enable pulse.

Structure
REQ-038 A shared package SHALL hold the state enum, opcode constants, and the ALUOp/ALUSrc/MemToReg/pc_sel encodings.
REQ-039 The combinational decoder SHALL be a single sub-module, cpu_decode, mapping IR to control-signal fields and an instruction class.

Verification
REQ-040 ADDI X1,X31,#5 with run=1 and instr_valid after 2 cycles -> ALUSrc=2, ALUOp=010, single RegWrite pulse in WB, retired=1.
REQ-041 LDURB -> xfer_size=1, loadB=1, MemToReg=1; STUR -> one MemWrite pulse in MEM, no RegWrite, retired increments.
REQ-042 B.cond LT with NF=1, OF=0 -> pc_sel=2, pc_we=1; same instruction with NF=OF=0 -> pc_sel=0.
REQ-043 Opcode 32'h0 -> ERR, err=1; run toggling changes nothing; reset low returns to IDLE with err=0.
REQ-044 Reset low during MEM of STUR -> MemWrite never pulses, retired unchanged at 0.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// Shared encodings for the LEGv8 multi-cycle sequencer: FSM states, opcodes,
// datapath select codes, instruction classes and the B.cond evaluator.
package cpu_seq_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  localparam logic [10:0] OP_ADDS  = 11'b10101011000;
  localparam logic [10:0] OP_SUBS  = 11'b11101011000;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_LDURB = 11'b00111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_STURB = 11'b00111000000;
  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
  localparam logic [8:0]  OP_MOVZ  = 9'b110100101;
  localparam logic [8:0]  OP_MOVK  = 9'b111100101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [5:0]  OP_B     = 6'b000101;

  localparam logic [2:0] ALU_PASS_B = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b011;

  localparam logic [1:0] SRC_DB     = 2'd0;
  localparam logic [1:0] SRC_DADDR9 = 2'd1;
  localparam logic [1:0] SRC_IMM12  = 2'd2;

  localparam logic [1:0] M2R_ALU  = 2'd0;
  localparam logic [1:0] M2R_MEM  = 2'd1;
  localparam logic [1:0] M2R_MOVZ = 2'd2;
  localparam logic [1:0] M2R_MOVK = 2'd3;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BR26   = 2'd1;
  localparam logic [1:0] PC_COND19 = 2'd2;

  typedef enum logic [2:0] {
    CLS_NONE, CLS_ALU, CLS_LOAD, CLS_STORE, CLS_MOV, CLS_B, CLS_BCOND, CLS_CBZ
  } iclass_e;

  function automatic logic cond_taken(input logic [3:0] cond, input logic zf,
                                      input logic nf, input logic of);
    case (cond)
      4'h0:    return zf;
      4'h1:    return !zf;
      4'hA:    return nf == of;
      4'hB:    return nf != of;
      4'hC:    return !zf && (nf == of);
      4'hD:    return zf || (nf != of);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_decode.sv
// Combinational opcode decoder: maps IR[31:21] to an instruction class and
// the datapath select fields that class needs while it executes.
module cpu_decode
  import cpu_seq_pkg::*;
(
  input  logic [10:0] op,
  output logic [2:0]  cls,
  output logic        reg2loc,
  output logic        set_flag,
  output logic        load_b,
  output logic [1:0]  alu_src,
  output logic [1:0]  mem_to_reg,
  output logic [2:0]  alu_op,
  output logic [3:0]  xfer_size
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the chain infers a latch.
    cls        = CLS_NONE;
    reg2loc    = 1'b0;
    set_flag   = 1'b0;
    load_b     = 1'b0;
    alu_src    = SRC_DB;
    mem_to_reg = M2R_ALU;
    alu_op     = ALU_PASS_B;
    xfer_size  = 4'd0;

    if (op == OP_ADDS || op == OP_SUBS) begin
      cls      = CLS_ALU;
      reg2loc  = 1'b1;
      set_flag = 1'b1;
      alu_op   = (op == OP_SUBS) ? ALU_SUB : ALU_ADD;
    end else if (op == OP_LDUR || op == OP_LDURB) begin
      cls        = CLS_LOAD;
      alu_src    = SRC_DADDR9;
      alu_op     = ALU_ADD;
      mem_to_reg = M2R_MEM;
      load_b     = (op == OP_LDURB);
      xfer_size  = (op == OP_LDURB) ? 4'd1 : 4'd8;
    end else if (op == OP_STUR || op == OP_STURB) begin
      cls       = CLS_STORE;
      alu_src   = SRC_DADDR9;
      alu_op    = ALU_ADD;
      xfer_size = (op == OP_STURB) ? 4'd1 : 4'd8;
    end else if (op[10:1] == OP_ADDI) begin
      cls     = CLS_ALU;
      alu_src = SRC_IMM12;
      alu_op  = ALU_ADD;
    end else if (op[10:2] == OP_MOVZ) begin
      cls        = CLS_MOV;
      mem_to_reg = M2R_MOVZ;
    end else if (op[10:2] == OP_MOVK) begin
      // Reg2Loc stays 0 so Db reads the old Rd value that MOVK merges into.
      cls        = CLS_MOV;
      mem_to_reg = M2R_MOVK;
    end else if (op[10:3] == OP_BCOND) begin
      cls = CLS_BCOND;
    end else if (op[10:3] == OP_CBZ) begin
      cls = CLS_CBZ;
    end else if (op[10:5] == OP_B) begin
      cls = CLS_B;
    end
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle LEGv8 control sequencer: fetch handshake, decode, per-class
// EXEC/MEM/WB sequencing, branch resolution and a retired-instruction count.
module cpu_seq_ctrl
  import cpu_seq_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  output logic             instr_req,
  input  logic             instr_valid,
  input  logic [31:0]      instr_in,
  output logic [31:0]      instr,
  input  logic             zero,
  input  logic             ZF,
  input  logic             NF,
  input  logic             OF,
  input  logic             CoF,
  output logic             Reg2Loc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             SetFlag,
  output logic             loadB,
  output logic [1:0]       ALUSrc,
  output logic [1:0]       MemToReg,
  output logic [2:0]       ALUOp,
  output logic [3:0]       xfer_size,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  logic [2:0] state, state_nx;
  logic [2:0] cls;
  logic       d_reg2loc, d_set_flag, d_load_b;
  logic [1:0] d_alu_src, d_mem_to_reg;
  logic [2:0] d_alu_op;
  logic [3:0] d_xfer_size;
  logic       is_branch, taken, last, active;
  logic       unused;

  // No supported condition code reads the carry flag.
  assign unused = CoF;

  cpu_decode u_decode (
    .op         (instr[31:21]),
    .cls        (cls),
    .reg2loc    (d_reg2loc),
    .set_flag   (d_set_flag),
    .load_b     (d_load_b),
    .alu_src    (d_alu_src),
    .mem_to_reg (d_mem_to_reg),
    .alu_op     (d_alu_op),
    .xfer_size  (d_xfer_size)
  );

  assign is_branch = (cls == CLS_B) || (cls == CLS_BCOND) || (cls == CLS_CBZ);
  assign active    = (state == S_EXEC) || (state == S_MEM) || (state == S_WB);
  assign last      = ((state == S_EXEC) && is_branch) ||
                     ((state == S_MEM) && (cls == CLS_STORE)) ||
                     (state == S_WB);

  always_comb begin
    taken = 1'b0;
    case (cls)
      CLS_B:     taken = 1'b1;
      CLS_BCOND: taken = cond_taken(instr[3:0], ZF, NF, OF);
      CLS_CBZ:   taken = zero;
      default:   taken = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    if (last) begin
      state_nx = run ? S_FETCH : S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (run) state_nx = S_FETCH;
        S_FETCH:  if (instr_valid) state_nx = S_DECODE;
        S_DECODE: state_nx = (cls == CLS_NONE) ? S_ERR : S_EXEC;
        S_EXEC:   state_nx = (cls == CLS_LOAD || cls == CLS_STORE) ? S_MEM : S_WB;
        S_MEM:    state_nx = S_WB;
        S_ERR:    state_nx = S_ERR;
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      instr   <= '0;
      retired <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state <= state_nx;
      if (state == S_FETCH && instr_valid) instr <= instr_in;
      if (last) retired <= retired + CNT_W'(1);
    end
  end

  // Every output is decoded from the registered state, so reset clears them at once.
  always_comb begin
    instr_req = (state == S_FETCH);
    err       = (state == S_ERR);
    Reg2Loc   = active && d_reg2loc;
    loadB     = active && d_load_b;
    ALUSrc    = active ? d_alu_src    : SRC_DB;
    MemToReg  = active ? d_mem_to_reg : M2R_ALU;
    ALUOp     = active ? d_alu_op     : ALU_PASS_B;
    xfer_size = active ? d_xfer_size  : 4'd0;
    SetFlag   = (state == S_EXEC) && d_set_flag;
    MemWrite  = (state == S_MEM) && (cls == CLS_STORE);
    RegWrite  = (state == S_WB);
    pc_we     = last;
    pc_sel    = PC_SEQ;
    if (state == S_EXEC && taken) pc_sel = (cls == CLS_B) ? PC_BR26 : PC_COND19;
  end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl: a table of single instructions with
// hand-computed control fields, plus reset, ERR and run-boundary sequences.
module tb_cpu_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset, run, instr_valid;
  logic [31:0] instr_in, instr;
  logic        zero, ZF, NF, OF, CoF;
  logic        instr_req, Reg2Loc, RegWrite, MemWrite, SetFlag, loadB;
  logic [1:0]  ALUSrc, MemToReg, pc_sel;
  logic [2:0]  ALUOp;
  logic [3:0]  xfer_size;
  logic        pc_we, err;
  logic [31:0] retired;

  int n_vec = 0;
  int n_bad = 0;
  int exp_ret = 0;

  always #5 clk = ~clk;

  cpu_seq_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .run(run), .instr_req(instr_req),
    .instr_valid(instr_valid), .instr_in(instr_in), .instr(instr),
    .zero(zero), .ZF(ZF), .NF(NF), .OF(OF), .CoF(CoF),
    .Reg2Loc(Reg2Loc), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .SetFlag(SetFlag), .loadB(loadB), .ALUSrc(ALUSrc), .MemToReg(MemToReg),
    .ALUOp(ALUOp), .xfer_size(xfer_size), .pc_we(pc_we), .pc_sel(pc_sel),
    .err(err), .retired(retired)
  );

  typedef struct {
    string       name;
    logic [31:0] op;
    int          dly;
    logic        zf, nf, of, zr;
    int          cyc, rw, mw, sf;
    logic [1:0]  psel, src, m2r;
    logic [2:0]  aop;
    logic        r2l;
    logic [3:0]  xs;
    logic        lb;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [31:0] op, input int dly,
                              input logic zf, input logic nf, input logic of, input logic zr,
                              input int cyc, input int rw, input int mw, input int sf,
                              input logic [1:0] psel, input logic [1:0] src,
                              input logic [2:0] aop, input logic [1:0] m2r,
                              input logic r2l, input logic [3:0] xs, input logic lb);
    vec_t v;
    v.name = name; v.op = op; v.dly = dly;
    v.zf = zf; v.nf = nf; v.of = of; v.zr = zr;
    v.cyc = cyc; v.rw = rw; v.mw = mw; v.sf = sf;
    v.psel = psel; v.src = src; v.aop = aop; v.m2r = m2r;
    v.r2l = r2l; v.xs = xs; v.lb = lb;
    return v;
  endfunction

  // Waits for the fetch request, holds off instr_valid for dly cycles, then
  // delivers op; returns at the negedge inside DECODE with run dropped.
  task automatic fetch(input string name, input logic [31:0] op, input int dly);
    int n = 0;
    run = 1'b1;
    while (!instr_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, ".req"}, instr_req, 1);
    repeat (dly) @(negedge clk);
    check({name, ".req_hold"}, instr_req, 1);
    instr_in    = op;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    instr_in    = '0;
    run         = 1'b0;
    check({name, ".ir"}, instr, op);
  endtask

  task automatic run_vec(input vec_t v);
    int cyc = 0, rw = 0, mw = 0, sf = 0, pw = 0, both = 0;
    logic [31:0] start;
    logic [1:0]  psel = '0, src = '0, m2r = '0;
    logic [2:0]  aop = '0;
    logic        r2l = 1'b0, lb = 1'b0;
    logic [3:0]  xs = '0;
    ZF = v.zf; NF = v.nf; OF = v.of; zero = v.zr;
    fetch(v.name, v.op, v.dly);
    start = retired;
    while (retired == start && cyc < 10) begin
      rw += int'(RegWrite);
      mw += int'(MemWrite);
      sf += int'(SetFlag);
      if (RegWrite && MemWrite) both++;
      if (pc_we) begin
        pw++;
        psel = pc_sel; src = ALUSrc; aop = ALUOp; m2r = MemToReg;
        r2l = Reg2Loc; xs = xfer_size; lb = loadB;
      end
      @(negedge clk);
      cyc++;
    end
    exp_ret++;
    check({v.name, ".cycles"}, cyc, v.cyc);
    check({v.name, ".regwrite"}, rw, v.rw);
    check({v.name, ".memwrite"}, mw, v.mw);
    check({v.name, ".setflag"}, sf, v.sf);
    check({v.name, ".rw_and_mw"}, both, 0);
    check({v.name, ".pc_we"}, pw, 1);
    check({v.name, ".pc_sel"}, psel, v.psel);
    check({v.name, ".alusrc"}, src, v.src);
    check({v.name, ".aluop"}, aop, v.aop);
    check({v.name, ".memtoreg"}, m2r, v.m2r);
    check({v.name, ".reg2loc"}, r2l, v.r2l);
    check({v.name, ".xfer_size"}, xs, v.xs);
    check({v.name, ".loadb"}, lb, v.lb);
    check({v.name, ".retired"}, retired, exp_ret);
    check({v.name, ".idle_after"}, instr_req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    reset = 1'b1; run = 1'b0; instr_valid = 1'b0; instr_in = '0;
    zero = 1'b0; ZF = 1'b0; NF = 1'b0; OF = 1'b0; CoF = 1'b0;

    //            name      op           dly zf nf of zr cyc rw mw sf psel src aop     m2r r2l xs lb
    vecs.push_back(mk("addi",   32'h910017E1, 2, 0, 0, 0, 0, 3, 1, 0, 0, 0, 2, 3'b010, 0, 0, 0, 0));
    vecs.push_back(mk("adds",   32'hAB000000, 0, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0, 3'b010, 0, 1, 0, 0));
    vecs.push_back(mk("subs",   32'hEB000000, 1, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0, 3'b011, 0, 1, 0, 0));
    vecs.push_back(mk("ldur",   32'hF8400000, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 1, 3'b010, 1, 0, 8, 0));
    vecs.push_back(mk("ldurb",  32'h38400000, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 1, 3'b010, 1, 0, 1, 1));
    vecs.push_back(mk("stur",   32'hF8000000, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0, 1, 3'b010, 0, 0, 8, 0));
    vecs.push_back(mk("sturb",  32'h38000000, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0, 1, 3'b010, 0, 0, 1, 0));
    vecs.push_back(mk("movz",   32'hD2800000, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 3'b000, 2, 0, 0, 0));
    vecs.push_back(mk("movk",   32'hF2800000, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 3'b000, 3, 0, 0, 0));
    vecs.push_back(mk("b",      32'h14000000, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 0, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk("blt_t",  32'h5400000B, 0, 0, 1, 0, 0, 2, 0, 0, 0, 2, 0, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk("blt_n",  32'h5400000B, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk("beq_t",  32'h54000000, 0, 1, 0, 0, 0, 2, 0, 0, 0, 2, 0, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk("beq_n",  32'h54000000, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk("bne_t",  32'h54000001, 0, 0, 0, 0, 0, 2, 0, 0, 0, 2, 0, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk("bge_t",  32'h5400000A, 0, 0, 1, 1, 0, 2, 0, 0, 0, 2, 0, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk("bgt_t",  32'h5400000C, 0, 0, 1, 1, 0, 2, 0, 0, 0, 2, 0, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk("bgt_n",  32'h5400000C, 0, 1, 1, 1, 0, 2, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk("ble_t",  32'h5400000D, 0, 0, 1, 0, 0, 2, 0, 0, 0, 2, 0, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk("bcE_n",  32'h5400000E, 0, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk("cbz_t",  32'hB4000000, 0, 0, 0, 0, 1, 2, 0, 0, 0, 2, 0, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk("cbz_n",  32'hB4000000, 0, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0));

    // Reset state, applied asynchronously away from any clock edge.
    #3 reset = 1'b0;
    #1;
    check("rst.instr_req", instr_req, 0);
    check("rst.ir", instr, 0);
    check("rst.retired", retired, 0);
    check("rst.err", err, 0);
    check("rst.enables", {RegWrite, MemWrite, SetFlag, pc_we, loadB, Reg2Loc}, 0);
    check("rst.selects", {ALUSrc, MemToReg, ALUOp, xfer_size, pc_sel}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("idle.no_req", instr_req, 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // run raised again before the final state: sequencer goes straight back to FETCH.
    ZF = 1'b0; NF = 1'b0; OF = 1'b0; zero = 1'b0;
    fetch("b_run", 32'h14000000, 0);
    run = 1'b1;
    @(negedge clk);
    check("b_run.pc_we", pc_we, 1);
    @(negedge clk);
    exp_ret++;
    check("b_run.retired", retired, exp_ret);
    check("b_run.refetch", instr_req, 1);

    // Unsupported opcode: ERR is sticky and ignores run.
    fetch("err", 32'h00000000, 0);
    @(negedge clk);
    check("err.set", err, 1);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      run = i[0];
      @(negedge clk);
      if (!err || instr_req || RegWrite || MemWrite || SetFlag || pc_we) bad++;
    end
    run = 1'b0;
    check("err.sticky", bad, 0);
    check("err.retired", retired, exp_ret);
    #2 reset = 1'b0;
    #1;
    check("err.rst_err", err, 0);
    check("err.rst_retired", retired, 0);
    check("err.rst_ir", instr, 0);
    @(negedge clk);
    reset = 1'b1;
    exp_ret = 0;
    @(negedge clk);
    check("err.idle", instr_req, 0);

    // Reset lands just after the clock edge that enters MEM of a STUR.
    fetch("stur_rst", 32'hF8000000, 0);
    @(negedge clk);
    check("stur_rst.exec_mw", MemWrite, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("stur_rst.mw_now", MemWrite, 0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (MemWrite || RegWrite || pc_we) bad++;
      if (i == 1) reset = 1'b1;
    end
    check("stur_rst.no_pulse", bad, 0);
    check("stur_rst.retired", retired, 0);
    check("stur_rst.idle", instr_req, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
